// File: rtl/alu_mul_scheduler_if.sv
// Requester and datapath bus of the ALU/multiplier scheduler.
// master: requesters plus datapath model; slave: the scheduler.
interface alu_mul_scheduler_if;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned RES_W = 16;

    // Requester side
    logic              req0_i;
    logic [OP_W-1:0]   op0_i;
    logic [DAT_W-1:0]  a0_i;
    logic [DAT_W-1:0]  b0_i;
    logic              req1_i;
    logic [OP_W-1:0]   op1_i;
    logic [DAT_W-1:0]  a1_i;
    logic [DAT_W-1:0]  b1_i;
    logic [1:0]        ack_o;
    logic [RES_W-1:0]  result_o;
    logic              err_o;
    logic [1:0]        grant_o;

    // Datapath side
    logic              enAlu;
    logic              enMul;
    logic [OP_W-1:0]   opcode_o;
    logic [DAT_W-1:0]  opA_o;
    logic [DAT_W-1:0]  opB_o;
    logic [DAT_W-1:0]  alu_res_i;
    logic [RES_W-1:0]  mul_res_i;
    logic              mul_done_i;

    modport master (
        output req0_i, op0_i, a0_i, b0_i,
        output req1_i, op1_i, a1_i, b1_i,
        output alu_res_i, mul_res_i, mul_done_i,
        input  ack_o, result_o, err_o, grant_o,
        input  enAlu, enMul, opcode_o, opA_o, opB_o
    );

    modport slave (
        input  req0_i, op0_i, a0_i, b0_i,
        input  req1_i, op1_i, a1_i, b1_i,
        input  alu_res_i, mul_res_i, mul_done_i,
        output ack_o, result_o, err_o, grant_o,
        output enAlu, enMul, opcode_o, opA_o, opB_o
    );
endinterface

// File: rtl/alu_mul_scheduler.sv
// Round-robin scheduler sharing one ALU and one multi-cycle multiplier between
// two requesters. One operation in flight: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature macro: ARB_TIMEOUT_EN (multiplier wait timeout, err_o).
module alu_mul_scheduler #(
    parameter logic [3:0]  MUL_OPCODE     = 4'd5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    alu_mul_scheduler_if.slave    bus,
    output logic [2:0]            state
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned RES_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;      // requester granted most recently
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         ack_q, ack_d;
    logic               en_alu_q, en_alu_d;
    logic               en_mul_q, en_mul_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [DAT_W-1:0]   op_a_q, op_a_d;
    logic [DAT_W-1:0]   op_b_q, op_b_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               sel1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // State and datapath-facing registers; reset drops any in-flight operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            grant_q  <= '0;
            ack_q    <= '0;
            en_alu_q <= 1'b0;
            en_mul_q <= 1'b0;
            opcode_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            en_alu_q <= en_alu_d;
            en_mul_q <= en_mul_d;
            opcode_q <= opcode_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state, arbitration and registered-output values
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack_d    = '0;
        en_alu_d = 1'b0;
        en_mul_d = 1'b0;
        opcode_d = opcode_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        sel1     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (bus.req0_i || bus.req1_i) begin
                    // Requester 1 wins when alone, or on a tie if 0 went last
                    sel1     = bus.req1_i && (!bus.req0_i || !last_q);
                    last_d   = sel1;
                    grant_d  = sel1 ? 2'b10 : 2'b01;
                    opcode_d = sel1 ? bus.op1_i : bus.op0_i;
                    op_a_d   = sel1 ? bus.a1_i  : bus.a0_i;
                    op_b_d   = sel1 ? bus.b1_i  : bus.b0_i;
                    // Enables are registered, so they are decided here to pulse during ISSUE
                    en_alu_d = (opcode_d != MUL_OPCODE);
                    en_mul_d = (opcode_d == MUL_OPCODE);
`ifdef ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (opcode_q != MUL_OPCODE) begin
                    result_d = {8'h00, bus.alu_res_i};
                    ack_d    = grant_q;
                    state_d  = S_RESP;
                end else if (bus.mul_done_i) begin
                    result_d = bus.mul_res_i;
                    ack_d    = grant_q;
                    state_d  = S_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    ack_d    = grant_q;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ack_o    = ack_q;
    assign bus.result_o = result_q;
    assign bus.grant_o  = grant_q;
    assign bus.enAlu    = en_alu_q;
    assign bus.enMul    = en_mul_q;
    assign bus.opcode_o = opcode_q;
    assign bus.opA_o    = op_a_q;
    assign bus.opB_o    = op_b_q;
    assign state        = state_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err_o    = err_q;
`else
    assign bus.err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mul_scheduler.sv
// Directed self-checking bench for alu_mul_scheduler.
module tb_alu_mul_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;

    alu_mul_scheduler_if bus ();

    alu_mul_scheduler #(.MUL_OPCODE(4'd5), .TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_i = 0; bus.op0_i = '0; bus.a0_i = '0; bus.b0_i = '0;
        bus.req1_i = 0; bus.op1_i = '0; bus.a1_i = '0; bus.b1_i = '0;
        bus.alu_res_i = '0; bus.mul_res_i = '0; bus.mul_done_i = 0;
    endtask

    // Advance until ack_o is seen or the budget runs out
    task automatic wait_ack(input int max, output int cycles, output bit seen);
        seen = 0;
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            cycles++;
            if (bus.ack_o != 2'b00) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        logic [48:0] all_out;
        idle_inputs();
        reset = 1;
        tick(); tick();
        all_out = {bus.ack_o, bus.result_o, bus.err_o, bus.grant_o, bus.enAlu, bus.enMul,
                   bus.opcode_o, bus.opA_o, bus.opB_o, state};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        reset = 0;
        tick(); tick(); tick();
        checks++;
        if ({state, bus.grant_o, bus.enAlu, bus.enMul} !== 7'd0) begin
            errors++; $display("FAIL reset_release_idle: state %0d grant %b en %b%b expected idle",
                               state, bus.grant_o, bus.enAlu, bus.enMul);
        end
    endtask

    task automatic test_alu_single();
        bus.op0_i = 4'd0; bus.a0_i = 8'h33; bus.b0_i = 8'hFF; bus.alu_res_i = 8'h32;
        bus.req0_i = 1;
        tick();
        checks++;
        if ({bus.enAlu, bus.enMul, bus.grant_o, state} !== {1'b1, 1'b0, 2'b01, 3'd1}) begin
            errors++; $display("FAIL alu_issue: enAlu %b enMul %b grant %b state %0d expected 1 0 01 1",
                               bus.enAlu, bus.enMul, bus.grant_o, state);
        end
        checks++;
        if ({bus.opcode_o, bus.opA_o, bus.opB_o} !== {4'd0, 8'h33, 8'hFF}) begin
            errors++; $display("FAIL alu_latch: got %h expected 033ff", {bus.opcode_o, bus.opA_o, bus.opB_o});
        end
        bus.a0_i = 8'h00;
        tick();
        checks++;
        if ({bus.enAlu, state, bus.opA_o} !== {1'b0, 3'd2, 8'h33}) begin
            errors++; $display("FAIL alu_wait: enAlu %b state %0d opA %h expected 0 2 33",
                               bus.enAlu, state, bus.opA_o);
        end
        tick();
        checks++;
        if ({bus.ack_o, bus.result_o, bus.err_o, state} !== {2'b01, 16'h0032, 1'b0, 3'd3}) begin
            errors++; $display("FAIL alu_ack: ack %b result %h err %b state %0d expected 01 0032 0 3",
                               bus.ack_o, bus.result_o, bus.err_o, state);
        end
        bus.req0_i = 0;
        tick();
        checks++;
        if ({bus.ack_o, bus.grant_o, state} !== {2'b00, 2'b00, 3'd0}) begin
            errors++; $display("FAIL alu_back_idle: ack %b grant %b state %0d expected 00 00 0",
                               bus.ack_o, bus.grant_o, state);
        end
    endtask

    task automatic test_arbitration();
        int cycles;
        bit seen;
        logic [1:0] exp_ack;
        pulse_reset();
        bus.op0_i = 4'd1; bus.a0_i = 8'h01; bus.b0_i = 8'h02;
        bus.op1_i = 4'd2; bus.a1_i = 8'h03; bus.b1_i = 8'h04;
        bus.alu_res_i = 8'hA5;
        bus.req0_i = 1; bus.req1_i = 1;
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ack(10, cycles, seen);
            checks++;
            if (!seen || bus.ack_o !== exp_ack || bus.result_o !== 16'h00A5) begin
                errors++; $display("FAIL arb_order_%0d: ack %b result %h seen %0d expected %b 00a5",
                                   k, bus.ack_o, bus.result_o, seen, exp_ack);
            end
        end
        bus.req0_i = 0; bus.req1_i = 0;
        tick(); tick();
    endtask

    task automatic test_mul();
        int mul_pulses;
        bus.op1_i = 4'd5; bus.a1_i = 8'h0F; bus.b1_i = 8'h11; bus.mul_done_i = 0;
        bus.req1_i = 1;
        tick();
        mul_pulses = int'(bus.enMul);
        checks++;
        if ({bus.enMul, bus.enAlu, bus.grant_o, state} !== {1'b1, 1'b0, 2'b10, 3'd1}) begin
            errors++; $display("FAIL mul_issue: enMul %b enAlu %b grant %b state %0d expected 1 0 10 1",
                               bus.enMul, bus.enAlu, bus.grant_o, state);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            mul_pulses += int'(bus.enMul);
        end
        checks++;
        if ({state, bus.ack_o, bus.enAlu} !== {3'd2, 2'b00, 1'b0}) begin
            errors++; $display("FAIL mul_waiting: state %0d ack %b enAlu %b expected 2 00 0",
                               state, bus.ack_o, bus.enAlu);
        end
        bus.mul_done_i = 1; bus.mul_res_i = 16'h00FF;
        tick();
        mul_pulses += int'(bus.enMul);
        checks++;
        if ({bus.ack_o, bus.result_o} !== {2'b10, 16'h00FF}) begin
            errors++; $display("FAIL mul_ack: ack %b result %h expected 10 00ff", bus.ack_o, bus.result_o);
        end
        checks++;
        if (mul_pulses !== 1) begin
            errors++; $display("FAIL mul_single_pulse: got %0d expected 1", mul_pulses);
        end
        bus.mul_done_i = 0; bus.req1_i = 0;
        tick(); tick();
    endtask

    task automatic test_mul_done_in_issue();
        bus.op0_i = 4'd5; bus.a0_i = 8'h02; bus.b0_i = 8'h03;
        bus.req0_i = 1;
        tick();
        bus.mul_done_i = 1; bus.mul_res_i = 16'h1234;
        tick();
        bus.mul_done_i = 0;
        checks++;
        if ({state, bus.ack_o} !== {3'd2, 2'b00}) begin
            errors++; $display("FAIL done_in_issue_ignored: state %0d ack %b expected 2 00", state, bus.ack_o);
        end
        tick(); tick();
        bus.mul_done_i = 1; bus.mul_res_i = 16'h0006;
        tick();
        checks++;
        if ({bus.ack_o, bus.result_o} !== {2'b01, 16'h0006}) begin
            errors++; $display("FAIL late_done_ack: ack %b result %h expected 01 0006", bus.ack_o, bus.result_o);
        end
        bus.mul_done_i = 0; bus.req0_i = 0;
        tick(); tick();
    endtask

    task automatic test_reset_midop();
        int cycles;
        bit seen;
        bus.op0_i = 4'd5; bus.req0_i = 1;
        tick(); tick();
        bus.req0_i = 0;
        #2 reset = 1;
        #1;
        checks++;
        if ({state, bus.ack_o, bus.grant_o, bus.enMul} !== {3'd0, 2'b00, 2'b00, 1'b0}) begin
            errors++; $display("FAIL reset_midop: state %0d ack %b grant %b enMul %b expected 0 00 00 0",
                               state, bus.ack_o, bus.grant_o, bus.enMul);
        end
        tick();
        reset = 0;
        bus.op0_i = 4'd3; bus.op1_i = 4'd4; bus.alu_res_i = 8'h5A;
        bus.req0_i = 1; bus.req1_i = 1;
        tick();
        checks++;
        if (bus.grant_o !== 2'b01) begin
            errors++; $display("FAIL rr_reinit: grant %b expected 01", bus.grant_o);
        end
        wait_ack(10, cycles, seen);
        checks++;
        if (!seen || bus.ack_o !== 2'b01) begin
            errors++; $display("FAIL rr_reinit_ack: ack %b seen %0d expected 01", bus.ack_o, seen);
        end
        bus.req0_i = 0; bus.req1_i = 0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        int cycles;
        bit seen;
        bus.op0_i = 4'd5; bus.a0_i = 8'h07; bus.b0_i = 8'h09; bus.mul_done_i = 0;
        bus.req0_i = 1;
        tick();
`ifdef ARB_TIMEOUT_EN
        wait_ack(40, cycles, seen);
        checks++;
        if (!seen || cycles !== 17) begin
            errors++; $display("FAIL timeout_latency: ticks after issue %0d seen %0d expected 17", cycles, seen);
        end
        checks++;
        if ({bus.ack_o, bus.err_o, bus.result_o} !== {2'b01, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL timeout_resp: ack %b err %b result %h expected 01 1 0000",
                               bus.ack_o, bus.err_o, bus.result_o);
        end
        bus.req0_i = 0;
        tick();
        bus.mul_done_i = 1; bus.mul_res_i = 16'hBEEF;
        tick();
        bus.mul_done_i = 0;
        tick();
        checks++;
        if ({state, bus.ack_o} !== {3'd0, 2'b00}) begin
            errors++; $display("FAIL late_done_in_idle: state %0d ack %b expected 0 00", state, bus.ack_o);
        end
`else
        seen = 0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (bus.ack_o != 2'b00) seen = 1;
        end
        checks++;
        if (state !== 3'd2 || seen || bus.err_o !== 1'b0) begin
            errors++; $display("FAIL no_timeout_hold: state %0d ack_seen %0d err %b after %0d cycles expected 2 0 0",
                               state, seen, bus.err_o, cycles);
        end
        bus.req0_i = 0;
        pulse_reset();
`endif
    endtask

    // Hard stop in case something never returns
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_single();
        test_arbitration();
        test_mul();
        test_mul_done_in_issue();
        test_reset_midop();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
